// File: rtl/serializer_piso_pkg.sv
// Shared definitions for the parallel-in/serial-out serializer: FSM state
// encodings and the default word length.
package serializer_piso_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/FlipFlopD.sv
// Positive-edge D flip-flop with asynchronous active-low clear; one storage
// cell of the serializer shift register.
module FlipFlopD (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) q <= 1'b0;
    else          q <= d;
  end

endmodule

// File: rtl/serializer_piso.sv
// Parallel-in/serial-out serializer, MSB first, with a one-cycle done pulse
// after the last bit has been consumed downstream.
module serializer_piso
  import serializer_piso_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

  localparam int unsigned   CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] sr, sr_next;
  logic [CW-1:0]    cnt, cnt_next;

  // The register stores sr_next every cycle; hold behaviour comes from the mux below.
  for (genvar i = 0; i < WIDTH; i++) begin : g_sr
    FlipFlopD u_ff (
      .clock   (clock),
      .reset_n (reset_n),
      .d       (sr_next[i]),
      .q       (sr[i])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    sr_next    = sr;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (load_valid) begin
          sr_next    = load_data;
          cnt_next   = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          if (cnt == LAST) begin
            state_next = DONE;
          end else begin
            sr_next  = {sr[WIDTH-2:0], 1'b0};
            cnt_next = cnt + CW'(1);
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // load_ready is gated by reset_n so it reads 0 while reset is held.
  assign load_ready = reset_n && (state == IDLE);
  assign sout_valid = (state == SHIFT);
  assign sout       = (state == SHIFT) && sr[WIDTH-1];
  assign done       = (state == DONE);

endmodule
